// File: rtl/ibis_dvi_mem_pkg.sv
// Shared types for the DVI/client burst-read memory arbiter.
// Holds the FSM and owner encodings plus the beat-counter sizing helper.
package ibis_dvi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_t;

    function automatic int beat_cnt_width(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/ibis_burst_watchdog.sv
// Tracks one in-flight burst: counts beats and cycles and flags a burst that ends wrongly or stalls.
// done/timeout/proto_err are same-cycle pulses so the arbiter can leave BURST on that edge.
module ibis_burst_watchdog
    import ibis_dvi_mem_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic beat,
    input  logic last,
    output logic done,
    output logic timeout,
    output logic proto_err
);

    localparam int BEAT_W = beat_cnt_width(BURST_LEN);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    logic [BEAT_W-1:0] beat_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              final_beat;

    assign final_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));

    // A burst ends on rlast or on the final beat, whichever comes first; disagreement is an error.
    assign done      = active && beat && (last || final_beat);
    assign proto_err = active && beat && (last != final_beat);
    assign timeout   = active && !done && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt <= '0;
            wd_cnt   <= '0;
        end else if (active) begin
            if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ibis_dvi_mem_arbiter.sv
// Shares one burst-read memory port between the DVI line prefetcher and a general client.
// Urgent display wins outright; otherwise requesters alternate, one burst outstanding at a time.
module ibis_dvi_mem_arbiter
    import ibis_dvi_mem_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int LEVEL_W      = 8,
    parameter int URGENT_LEVEL = 16,
    parameter int BURST_LEN    = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               enable,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    input  logic [LEVEL_W-1:0] disp_level,
    output logic               disp_grant,
    output logic               disp_rvalid,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_grant,
    output logic               cpu_rvalid,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic               mem_rvalid,
    input  logic               mem_rlast,
    output logic               err_timeout,
    output logic               err_protocol,
    output logic               busy,
    output arb_state_t         dbg_state
);

    arb_state_t state, state_next;
    owner_t     owner, rr_ptr, winner;
    logic       urgent, start, accept, in_burst;
    logic       wd_done, wd_timeout, wd_proto;

    assign urgent   = disp_req && (disp_level < LEVEL_W'(URGENT_LEVEL));
    assign in_burst = (state == BURST);

    always_comb begin
        winner = rr_ptr;
        if (urgent || (disp_req && !cpu_req)) begin
            winner = OWN_DISP;
        end else if (cpu_req && !disp_req) begin
            winner = OWN_CPU;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (disp_req || cpu_req)) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req && mem_ack) begin
                    accept     = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (wd_done || wd_timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            owner        <= OWN_DISP;
            rr_ptr       <= OWN_DISP;
            disp_grant   <= 1'b0;
            cpu_grant    <= 1'b0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            disp_grant <= accept && (owner == OWN_DISP);
            cpu_grant  <= accept && (owner == OWN_CPU);
            if (start) begin
                owner    <= winner;
                rr_ptr   <= (winner == OWN_DISP) ? OWN_CPU : OWN_DISP;
                mem_addr <= (winner == OWN_DISP) ? disp_addr : cpu_addr;
                mem_req  <= 1'b1;
            end
            if (accept) begin
                mem_req <= 1'b0;
            end
            if (wd_timeout) begin
                err_timeout <= 1'b1;
            end
            // Beats outside BURST (stray or post-timeout) are never routed, only flagged.
            if (wd_proto || (mem_rvalid && !in_burst)) begin
                err_protocol <= 1'b1;
            end
        end
    end

    assign disp_rvalid = mem_rvalid && in_burst && (owner == OWN_DISP);
    assign cpu_rvalid  = mem_rvalid && in_burst && (owner == OWN_CPU);
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    ibis_burst_watchdog #(
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (aclk),
        .rst       (areset),
        .clear     (accept),
        .active    (in_burst),
        .beat      (mem_rvalid),
        .last      (mem_rlast),
        .done      (wd_done),
        .timeout   (wd_timeout),
        .proto_err (wd_proto)
    );

endmodule

// File: doc/ibis_dvi_mem_arbiter.md
Name: ibis_dvi_mem_arbiter

Overview:
- Shares one burst-read memory port between two requesters:
  - the DVI scanline prefetcher, which fills the line buffer feeding the three ibis_tmds channels;
  - a general client (CPU/blitter).
- Display gets absolute priority when its line buffer runs low. Otherwise the two alternate round-robin.
- One burst is outstanding at a time. A watchdog and a protocol checker catch a stuck or misbehaving memory.

Parameters:
ADDR_W, 24, width of burst start address
LEVEL_W, 8, width of display line-buffer fill level
URGENT_LEVEL, 16, disp_level below this value makes display urgent
BURST_LEN, 8, beats per burst (>=2)
TIMEOUT, 255, max cycles from mem_ack to mem_rlast before abort

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
enable  in  1  permit new arbitration; an in-flight burst always completes
disp_req  in  1  display burst request; held until disp_grant
disp_addr  in  ADDR_W  display burst address; stable while disp_req
disp_level  in  LEVEL_W  display line-buffer fill level
disp_grant  out  1  one-cycle pulse: display burst accepted by memory
disp_rvalid  out  1  read beat belongs to display
cpu_req  in  1  client burst request; held until cpu_grant
cpu_addr  in  ADDR_W  client burst address
cpu_grant  out  1  one-cycle pulse: client burst accepted
cpu_rvalid  out  1  read beat belongs to client
mem_req  out  1  burst request to memory
mem_addr  out  ADDR_W  burst address to memory
mem_ack  in  1  memory accepts request (qualified by mem_req)
mem_rvalid  in  1  read beat valid
mem_rlast  in  1  last beat of burst
err_timeout  out  1  sticky: watchdog expired
err_protocol  out  1  sticky: rlast/beat-count mismatch or stray beat
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, areset=1 at clock edge):
  - state IDLE, mem_req=0, mem_addr=0, both grants 0, both rvalids 0, busy=0, errors cleared.
  - Round-robin pointer set to favour display.
  - A reset mid-burst abandons the burst.
- States: IDLE, ISSUE, BURST.
- IDLE:
  - Stay here when enable=0 or no request is present.
  - Otherwise pick a winner, register owner, and load mem_addr from the winner's address. mem_req=1 from the next cycle, so request-to-mem_req latency is 1 cycle. Go to ISSUE.
- Winner rule:
  - If disp_req and disp_level < URGENT_LEVEL, display wins.
  - Else if only one requester is present, it wins.
  - Else the pointer decides.
  - After each grant the pointer moves to the non-owner. Urgent grants also move it.
- ISSUE:
  - Hold mem_req and mem_addr until mem_ack.
  - On mem_ack: mem_req=0 next cycle; the owner's grant pulses for 1 cycle, registered (the cycle after the handshake). Clear the beat counter and the watchdog, then go to BURST.
  - A requester dropping req in ISSUE is a client protocol violation. The arbiter ignores it and completes the burst.
- BURST:
  - Each mem_rvalid increments the beat counter. It is routed combinationally: disp_rvalid/cpu_rvalid = mem_rvalid and owner match. Read data is wired externally.
  - mem_rlast with mem_rvalid returns to IDLE next cycle.
  - If mem_rlast arrives on a beat other than BURST_LEN-1, or beat BURST_LEN-1 arrives without mem_rlast: set err_protocol and still return to IDLE on rlast, or after beat BURST_LEN-1 respectively.
- Watchdog:
  - Counts cycles in BURST.
  - When it reaches TIMEOUT: set err_timeout and return to IDLE. Late beats after that are not routed and set err_protocol.
- mem_rvalid in IDLE or ISSUE is a stray beat: set err_protocol and route to no one.
- Back-to-back bursts: at best 1 idle cycle (the IDLE decision cycle) between rlast and the next mem_req.
- Errors clear only on areset.

Decomposition:
- Package ibis_dvi_mem_pkg holds:
  - state enum (IDLE/ISSUE/BURST);
  - owner enum (OWN_DISP/OWN_CPU);
  - helper function computing the beat-counter width as clog2(BURST_LEN).
- Natural sub-module ibis_burst_watchdog: beat counter, timeout counter, rlast/count checking. It outputs done, timeout, and proto_err pulses.

Test Plan:
- Single display burst: disp_req=1, disp_addr=0x000100, disp_level=40, mem_ack after 3 cycles, 8 beats with rlast on beat 7 -> mem_req rises 1 cycle after disp_req, mem_addr=0x000100, disp_grant 1-cycle pulse, 8 disp_rvalid, cpu_rvalid=0, busy drops after rlast.
- Round-robin: both req held, disp_level=100 -> grants alternate DISP, CPU, DISP, CPU over 4 bursts.
- Urgency: both req, pointer on CPU, disp_level=10 -> display wins. Repeat with disp_level=16 -> CPU wins.
- Protocol: mem_rlast on beat 5 -> err_protocol=1, return to IDLE, next request still served. Also a stray mem_rvalid in IDLE -> err_protocol=1, no rvalid routed.
- Timeout: mem_ack then no beats for 255 cycles -> err_timeout=1, state IDLE. A late beat is not routed.
- Reset and enable:
  - areset asserted at beat 3 -> next cycle mem_req=0, busy=0, errors=0.
  - enable=0 with disp_req=1 -> no mem_req.
  - enable dropped mid-burst -> burst completes all 8 beats.
